// File: rtl/instr_loader.sv
// Program loader: receives a framed byte stream (16-bit word count, little-endian
// instruction words, 8-bit additive checksum), writes each assembled word into
// instruction memory and keeps the CPU held until a load completes cleanly.
module instr_loader #(
  parameter int addr_size = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  // Largest legal word count: the whole memory.
  localparam logic [16:0] max_words = 17'(1) << addr_size;
  localparam logic [addr_size:0] word_one = (addr_size + 1)'(1);

  state_t               state;
  logic [7:0]           cnt_lo;
  logic [addr_size:0]   word_total;
  logic [addr_size:0]   word_cnt;
  logic [1:0]           byte_idx;
  logic [23:0]          word_buf;
  logic [7:0]           sum;

  logic                 accept;
  logic [15:0]          hdr_count;

  assign accept    = rx_valid & rx_ready;
  assign hdr_count = {rx_data, cnt_lo};

  // Session FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cnt_lo     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      sum        <= '0;
    end else begin
      // The write strobe is a single-cycle pulse unless re-armed below.
      mem_we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= HDR_LO;
            rx_ready <= 1'b1;
            busy     <= 1'b1;
            cpu_hold <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            word_cnt <= '0;
            byte_idx <= '0;
            sum      <= '0;
          end
        end
        HDR_LO: begin
          if (accept) begin
            cnt_lo <= rx_data;
            state  <= HDR_HI;
          end
        end
        HDR_HI: begin
          if (accept) begin
            if (hdr_count == 16'd0 || {1'b0, hdr_count} > max_words) begin
              state    <= ERR;
              rx_ready <= 1'b0;
              busy     <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              word_total <= (addr_size + 1)'(hdr_count);
              state      <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            sum <= sum + rx_data;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                // Word complete: issue the write next cycle, stream keeps flowing.
                mem_we    <= 1'b1;
                mem_wdata <= {rx_data, word_buf};
                mem_addr  <= 32'({word_cnt[addr_size-1:0], 2'b00});
                word_cnt  <= word_cnt + word_one;
                if ((word_cnt + word_one) == word_total) begin
                  state <= CHK;
                end
              end
            endcase
            byte_idx <= byte_idx + 2'd1;
          end
        end
        CHK: begin
          if (accept) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == sum) begin
              state    <= DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          rx_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: frames are streamed byte by byte and
// every expected memory write is queued, then matched against mem_we pulses.
module tb_instr_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  logic [31:0] frame_words[$];
  logic [31:0] last_addr = '1;
  logic [63:0] sb_entry;

  instr_loader #(.addr_size(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_q.size() == 0) begin
        check("spurious_we", 1, 0);
      end else begin
        sb_entry = exp_q.pop_front();
        check("we_addr", mem_addr, sb_entry[63:32]);
        check("we_data", mem_wdata, sb_entry[31:0]);
      end
      check("addr_upper", mem_addr[31:10], 0);
      last_addr = mem_addr;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    int t;
    if (gaps) begin
      g = $urandom_range(0, 2);
      rx_valid = 1'b0;
      for (int i = 0; i < g; i++) begin
        @(posedge clk); #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 0, 1);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
  endtask

  // Streams header, frame_words and checksum; optional start pulse after byte mid_start.
  task automatic send_frame(input logic [15:0] cnt, input bit bad_chk, input bit gaps,
                            input int mid_start);
    logic [7:0] s;
    logic [31:0] w;
    int k;
    s = 8'd0;
    k = 0;
    send_byte(cnt[7:0], gaps);
    send_byte(cnt[15:8], gaps);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      exp_q.push_back({32'(i * 4), w});
      for (int j = 0; j < 4; j++) begin
        send_byte(w[8*j +: 8], gaps);
        s = s + w[8*j +: 8];
        if (k == mid_start) begin
          rx_valid = 1'b0;
          pulse_start();
          check("mid_start_busy", busy, 1);
          check("mid_start_ready", rx_ready, 1);
        end
        k++;
      end
    end
    send_byte(bad_chk ? s + 8'd1 : s, gaps);
    rx_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 0);
  endtask

  task automatic check_status(input string tag, input bit b, input bit d, input bit e,
                              input bit h);
    check({tag, "_busy"}, busy, b);
    check({tag, "_done"}, done, d);
    check({tag, "_error"}, error, e);
    check({tag, "_hold"}, cpu_hold, h);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rx_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check_status("rst", 0, 0, 0, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic two-word frame, no gaps.
    frame_words = '{32'h00000013, 32'h12345678};
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", rx_ready, 1);
    send_frame(16'd2, 1'b0, 1'b0, -1);
    check_status("good", 0, 1, 0, 0);
    check("good_ready", rx_ready, 0);
    drain();

    // Same frame, corrupted checksum.
    pulse_start();
    check("restart_hold", cpu_hold, 1);
    check("restart_done", done, 0);
    send_frame(16'd2, 1'b1, 1'b0, -1);
    check_status("badchk", 0, 0, 1, 1);
    drain();

    // Zero-length header.
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    check_status("cnt0", 0, 0, 1, 1);
    check("cnt0_ready", rx_ready, 0);
    drain();

    // Header larger than memory (257 words).
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    rx_valid = 1'b0;
    check_status("cnt257", 0, 0, 1, 1);
    drain();

    // Full-memory frame with random valid gaps.
    frame_words.delete();
    for (int i = 0; i < 256; i++) frame_words.push_back(32'hA5000000 + 32'(i * 3));
    pulse_start();
    send_frame(16'd256, 1'b0, 1'b1, -1);
    check_status("full", 0, 1, 0, 0);
    drain();
    check("full_last_addr", last_addr, 32'h3FC);

    // Start pulse in the middle of DATA is ignored.
    frame_words = '{32'hDEADBEEF, 32'h01020304, 32'hCAFEF00D};
    pulse_start();
    send_frame(16'd3, 1'b0, 1'b0, 5);
    check_status("midstart", 0, 1, 0, 0);
    drain();

    // Reset after the second byte of word 1.
    frame_words = '{32'h11223344, 32'h55667788};
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    exp_q.push_back({32'h0, 32'h11223344});
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h88, 1'b0);
    send_byte(8'h77, 1'b0);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", rx_ready, 0);
    check("midrst_we", mem_we, 0);
    check("midrst_addr", mem_addr, 0);
    check("midrst_wdata", mem_wdata, 0);
    check_status("midrst", 0, 0, 0, 1);
    drain();
    frame_words = '{32'h0BADC0DE};
    pulse_start();
    send_frame(16'd1, 1'b0, 1'b0, -1);
    check_status("postrst", 0, 1, 0, 0);
    drain();

    // Reload after a successful session.
    pulse_start();
    check("reload_hold", cpu_hold, 1);
    check("reload_done", done, 0);
    check("reload_busy", busy, 1);
    frame_words = '{32'h00000093, 32'h00100113, 32'hFFF00193, 32'h00000073};
    send_frame(16'd4, 1'b0, 1'b1, -1);
    check_status("reload", 0, 1, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
